// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-lite initiator that turns queued client commands into pipelined single transfers.
// Latency: a command accepted at edge N is NONSEQ after N+1, in data phase after N+2, and completes after N+3.
//   Each wait state adds one cycle.
// Backpressure: cmd_ready drops when the command FIFO is full. hready=0 freezes the bus pipeline.
//   Responses cannot be stalled.
//
// Ports:
//   hclk, hresetn            clock and synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_write, cmd_addr, cmd_wdata carry the command
//   haddr/htrans/hwrite      AHB address phase
//   hwdata                   AHB write data, driven during the data phase
//   hrdata/hready            slave read data and ready
//   rsp_valid/rsp_addr/rsp_rdata  one-cycle read completion
//   wr_done                  one-cycle write completion
//   stat_wr_cnt/stat_rd_cnt/stat_wait_cnt  saturating counters, present only with AHB_MASTER_STATS_EN
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 8,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WORD_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [WORD_WIDTH-1:0] hwdata,
  input  logic [WORD_WIDTH-1:0] hrdata,
  input  logic                  hready,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done
`ifdef AHB_MASTER_STATS_EN
  ,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_wait_cnt
`endif
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO. The pointers carry one extra wrap bit, so equal pointers mean
  // empty, and pointers that differ only in the wrap bit mean full.
  // ---------------------------------------------------------------------------
  cmd_t          fifo_q [CMD_DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  cmd_t          cmd_in, head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // cmd_ready comes from the full flag only. A pop in the same cycle cannot free a slot early.
  assign cmd_ready  = hresetn && !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  // The pop looks only at registered FIFO state.
  // A command pushed this cycle therefore cannot be issued until the next edge.
  assign pop        = hready && !fifo_empty;

  assign cmd_in     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign head       = fifo_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge hclk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= cmd_in;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus pipeline: address phase (AP) -> data phase (DP) -> completion pulse.
  // ap_wdata rides with the address phase. This keeps hwdata aligned with its
  // own transfer when the transfer moves into the data phase.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] haddr_q,    haddr_d;
  logic [1:0]            htrans_q,   htrans_d;
  logic                  hwrite_q,   hwrite_d;
  logic [WORD_WIDTH-1:0] ap_wdata_q, ap_wdata_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [ADDR_WIDTH-1:0] dp_addr_q,  dp_addr_d;
  logic [WORD_WIDTH-1:0] hwdata_q,   hwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q,  rsp_addr_d;
  logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  wr_done_q,   wr_done_d;

  always_comb begin
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_addr_d   = dp_addr_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_done_d   = 1'b0;

    // With hready low, everything above holds and no completion pulse is produced.
    if (hready) begin
      dp_valid_d = (htrans_q == HTRANS_NONSEQ);
      dp_write_d = hwrite_q;
      dp_addr_d  = haddr_q;
      hwdata_d   = ap_wdata_q;

      if (!fifo_empty) begin
        haddr_d    = head.addr;
        hwrite_d   = head.write;
        ap_wdata_d = head.wdata;
        htrans_d   = HTRANS_NONSEQ;
      end else begin
        htrans_d   = HTRANS_IDLE;
      end

      if (dp_valid_q) begin
        if (dp_write_q) begin
          wr_done_d   = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = dp_addr_q;
          rsp_rdata_d = hrdata;
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_done   = wr_done_q;

`ifdef AHB_MASTER_STATS_EN
  // The counters step on the same edge that raises the matching pulse.
  logic [15:0] stat_wr_q, stat_rd_q, stat_wait_q;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      stat_wr_q   <= '0;
      stat_rd_q   <= '0;
      stat_wait_q <= '0;
    end else begin
      if (wr_done_d && (stat_wr_q != 16'hFFFF))
        stat_wr_q <= stat_wr_q + 16'd1;
      if (rsp_valid_d && (stat_rd_q != 16'hFFFF))
        stat_rd_q <= stat_rd_q + 16'd1;
      if (!hready && dp_valid_q && (stat_wait_q != 16'hFFFF))
        stat_wait_q <= stat_wait_q + 16'd1;
    end
  end

  assign stat_wr_cnt   = stat_wr_q;
  assign stat_rd_cnt   = stat_rd_q;
  assign stat_wait_cnt = stat_wait_q;
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed stimulus for ahb_lite_master, attached to a small AHB memory slave.
// A transaction-level model predicts every bus output and every response on every cycle.
// The directed sections add fixed expected values.
module tb_ahb_lite_master;
  localparam int AW    = 4;
  localparam int WW    = 8;
  localparam int DEPTH = 4;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [WW-1:0] cmd_wdata;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [WW-1:0] hwdata, hrdata;
  logic          hready;
  logic          rsp_valid, wr_done;
  logic [AW-1:0] rsp_addr;
  logic [WW-1:0] rsp_rdata;
`ifdef AHB_MASTER_STATS_EN
  logic [15:0]   stat_wr_cnt, stat_rd_cnt, stat_wait_cnt;
`endif

  always #5 hclk = ~hclk;

  ahb_lite_master #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CMD_DEPTH(DEPTH)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done)
`ifdef AHB_MASTER_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_wait_cnt(stat_wait_cnt)
`endif
  );

  // Memory slave: latches the address phase, returns read data combinationally during the data phase,
  // and commits write data when the data phase completes.
  logic [WW-1:0] smem [16];
  logic          s_dp_vld = 1'b0;
  logic          s_dp_wr = 1'b0;
  logic [AW-1:0] s_dp_addr = '0;
  always @(posedge hclk) begin
    if (!hresetn) begin
      s_dp_vld <= 1'b0;
    end else if (hready) begin
      if (s_dp_vld && s_dp_wr) smem[s_dp_addr] <= hwdata;
      s_dp_vld  <= (htrans == 2'b10);
      s_dp_addr <= haddr;
      s_dp_wr   <= hwrite;
    end
  end
  assign hrdata = smem[s_dp_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model. Count the posedges that see hready=1 (ready edges).
  // - A command pushed at some edge is issued at the first ready edge after it.
  // - It is also issued no earlier than one ready edge after the previous command.
  // - It completes two ready edges after it is issued.
  // - Completions update the reference memory in order.
  // At each negedge, apply the edge just taken (inputs sampled at the last negedge),
  // compare the outputs, then sample the inputs for the next edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    int            issue;
  } ent_t;

  ent_t          q[$];
  logic [WW-1:0] ref_mem [16];
  int            ridx = 0;
  int            last_issue = 0;
  logic          m_seen = 1'b0;
  logic          s_rst_n, s_rdy, s_push, s_w;
  logic [AW-1:0] s_a;
  logic [WW-1:0] s_d;
  logic [1:0]    e_htrans;
  logic [AW-1:0] e_haddr, e_raddr;
  logic          e_hwrite, e_rsp, e_wr, e_rst;
  logic [WW-1:0] e_rdata;

  always @(negedge hclk) begin
    ent_t c;
    ent_t n;
    int   iss;
    int   occ;
    if (m_seen) begin
      if (!s_rst_n) begin
        q.delete();
        last_issue = ridx;
        e_htrans = 2'b00; e_haddr = '0; e_hwrite = 1'b0;
        e_rsp = 1'b0; e_wr = 1'b0; e_rst = 1'b1;
      end else begin
        e_rsp = 1'b0; e_wr = 1'b0; e_rst = 1'b0;
        if (s_rdy) begin
          ridx++;
          if (q.size() > 0 && q[0].issue + 2 == ridx) begin
            c = q.pop_front();
            if (c.w) begin
              e_wr = 1'b1;
              ref_mem[c.a] = c.d;
            end else begin
              e_rsp = 1'b1;
              e_raddr = c.a;
              e_rdata = ref_mem[c.a];
            end
          end
          e_htrans = 2'b00;
          foreach (q[i]) if (q[i].issue == ridx) begin
            e_htrans = 2'b10; e_haddr = q[i].a; e_hwrite = q[i].w;
          end
        end
        if (s_push) begin
          iss = ridx + 1;
          if (last_issue + 1 > iss) iss = last_issue + 1;
          last_issue = iss;
          n.w = s_w; n.a = s_a; n.d = s_d; n.issue = iss;
          q.push_back(n);
        end
      end

      chk("htrans", 32'(htrans), 32'(e_htrans));
      chk("haddr", 32'(haddr), 32'(e_haddr));
      chk("hwrite", 32'(hwrite), 32'(e_hwrite));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("wr_done", 32'(wr_done), 32'(e_wr));
      if (e_rsp) begin
        chk("rsp_addr", 32'(rsp_addr), 32'(e_raddr));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      end
      if (e_rst) chk("hwdata_rst", 32'(hwdata), 32'h0);
      else foreach (q[i]) if (q[i].issue == ridx - 1 && q[i].w)
        chk("hwdata", 32'(hwdata), 32'(q[i].d));
      occ = 0;
      foreach (q[i]) if (q[i].issue > ridx) occ++;
      chk("cmd_ready", 32'(cmd_ready), 32'(hresetn && (occ < DEPTH)));
    end
    m_seen  = 1'b1;
    s_rst_n = hresetn;
    s_rdy   = hready;
    s_push  = cmd_valid && cmd_ready;
    s_w     = cmd_write;
    s_a     = cmd_addr;
    s_d     = cmd_wdata;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d,
                      output int acc);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    acc = -1;
    for (int k = 0; k < 40; k++) begin
      if (cmd_ready) begin
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (acc < 0) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sig(input int sel, output int at);
    at = -1;
    for (int k = 0; k < 30; k++) begin
      if ((sel == 0) ? wr_done : rsp_valid) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) chk((sel == 0) ? "wr_done_timeout" : "rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, t, nwr, nrd;
    logic [WW-1:0] rd;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    hready = 1'b1; hresetn = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", 32'(haddr), 32'h0);
    chk("rst_hwdata", 32'(hwdata), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    hresetn = 1'b1;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);

    // Write then read of the same address
    push(1'b1, 4'h0, 8'hA5, a0);
    push(1'b0, 4'h0, 8'h00, a1);
    wait_sig(0, t);
    chk("wr_latency", 32'(t - a0), 32'd3);
    wait_sig(1, t);
    chk("rd_latency", 32'(t - a1), 32'd3);
    chk("rd_addr0", 32'(rsp_addr), 32'h0);
    chk("rd_data0", 32'(rsp_rdata), 32'hA5);
    chk("mem0", 32'(smem[0]), 32'hA5);
    tick(); tick();

    // Back-to-back writes
    push(1'b1, 4'h1, 8'h11, a1);
    push(1'b1, 4'h2, 8'h22, a2);
    chk("b2b_htrans1", 32'(htrans), 32'h2);
    chk("b2b_haddr1", 32'(haddr), 32'h1);
    push(1'b1, 4'h3, 8'h33, a3);
    chk("b2b_htrans2", 32'(htrans), 32'h2);
    chk("b2b_haddr2", 32'(haddr), 32'h2);
    chk("b2b_hwdata1", 32'(hwdata), 32'h11);
    wait_sig(0, t);
    chk("b2b_wr_lat", 32'(t - a1), 32'd3);
    chk("b2b_htrans3", 32'(htrans), 32'h2);
    chk("b2b_haddr3", 32'(haddr), 32'h3);
    chk("b2b_hwdata2", 32'(hwdata), 32'h22);
    tick();
    chk("b2b_wr2", 32'(wr_done), 32'h1);
    chk("b2b_hwdata3", 32'(hwdata), 32'h33);
    chk("b2b_idle", 32'(htrans), 32'h0);
    tick();
    chk("b2b_wr3", 32'(wr_done), 32'h1);
    tick();
    chk("b2b_wr_end", 32'(wr_done), 32'h0);
    tick();

    // Two wait states during the data phase of a read of addr 1
    push(1'b0, 4'h1, 8'h00, a1);
    push(1'b0, 4'h2, 8'h00, a2);
    tick();
    hready = 1'b0;
    tick(); tick();
    chk("ws_haddr", 32'(haddr), 32'h2);
    chk("ws_htrans", 32'(htrans), 32'h2);
    chk("ws_hwrite", 32'(hwrite), 32'h0);
    chk("ws_no_rsp", 32'(rsp_valid), 32'h0);
    hready = 1'b1;
    wait_sig(1, t);
    chk("ws_rd_latency", 32'(t - a1), 32'd5);
    chk("ws_rd_addr", 32'(rsp_addr), 32'h1);
    chk("ws_rd_data", 32'(rsp_rdata), 32'h11);
    tick();
    chk("ws_rd2_valid", 32'(rsp_valid), 32'h1);
    chk("ws_rd2_data", 32'(rsp_rdata), 32'h22);
    tick(); tick();

    // FIFO full while the bus is stalled
    hready = 1'b0;
    push(1'b1, 4'h8, 8'h80, a0);
    push(1'b1, 4'h9, 8'h81, a1);
    push(1'b1, 4'hA, 8'h82, a2);
    push(1'b1, 4'hB, 8'h83, a3);
    chk("full_ready", 32'(cmd_ready), 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8; cmd_wdata = 8'h00;
    tick();
    chk("full_hold", 32'(cmd_ready), 32'h0);
    hready = 1'b1;
    tick();
    chk("full_freed", 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    nwr = 0; nrd = 0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wr_done) nwr++;
      if (rsp_valid) begin
        nrd++;
        rd = rsp_rdata;
      end
    end
    chk("full_nwr", 32'(nwr), 32'd4);
    chk("full_nrd", 32'(nrd), 32'd1);
    chk("full_rdata", 32'(rd), 32'h80);
`ifdef AHB_MASTER_STATS_EN
    chk("stat_wr", 32'(stat_wr_cnt), 32'd8);
    chk("stat_rd", 32'(stat_rd_cnt), 32'd4);
    chk("stat_wait", 32'(stat_wait_cnt), 32'd2);
`endif

    // Reset during the data phase of a read
    push(1'b0, 4'h1, 8'h00, a0);
    tick(); tick();
    hresetn = 1'b0;
    tick();
    chk("mrst_rsp", 32'(rsp_valid), 32'h0);
    chk("mrst_htrans", 32'(htrans), 32'h0);
    chk("mrst_haddr", 32'(haddr), 32'h0);
    chk("mrst_hwdata", 32'(hwdata), 32'h0);
    chk("mrst_wr_done", 32'(wr_done), 32'h0);
    chk("mrst_ready", 32'(cmd_ready), 32'h0);
`ifdef AHB_MASTER_STATS_EN
    chk("mrst_stat_wr", 32'(stat_wr_cnt), 32'd0);
    chk("mrst_stat_rd", 32'(stat_rd_cnt), 32'd0);
    chk("mrst_stat_wait", 32'(stat_wait_cnt), 32'd0);
`endif
    tick();
    hresetn = 1'b1;
    tick();
    chk("mrst_rel_ready", 32'(cmd_ready), 32'h1);
    chk("mrst_rel_rsp", 32'(rsp_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mrst_no_rsp", 32'(rsp_valid), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
